// File: rtl/e_pipe_reg.sv
`default_nettype none
// ============================================================================
// e_pipe_reg : Y86-64 decode-to-execute pipeline register with forwarding
// Revision   : 1.0  initial release
// ============================================================================
module e_pipe_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [63:0] rf_valA,
  input  logic [63:0] rf_valB,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstM,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] m_valM,
  input  logic [63:0] M_valE,
  input  logic [3:0]  W_dstM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valM,
  input  logic [63:0] W_valE,
  input  logic        E_stall,
  input  logic        E_bubble,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [15:0] bubble_count
);

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] RRSP    = 4'h4;
  localparam logic [3:0] SAOK    = 4'h1;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  logic [3:0]  d_dstE;
  logic [3:0]  d_dstM;
  logic [63:0] d_valA;
  logic [63:0] d_valB;

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      IRRMOVQ: begin d_srcA = D_rA; d_dstE = D_rB; end
      IIRMOVQ: begin d_dstE = D_rB; end
      IRMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
      IMRMOVQ: begin d_srcB = D_rB; d_dstM = D_rA; end
      IOPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
      ICALL:   begin d_srcB = RRSP; d_dstE = RRSP; end
      IRET:    begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; end
      IPUSHQ:  begin d_srcA = D_rA; d_srcB = RRSP; d_dstE = RRSP; end
      IPOPQ:   begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; d_dstM = D_rA; end
      default: ;
    endcase
  end

  // A source of RNONE never matches, even against an RNONE destination.
  always_comb begin
    d_valA = rf_valA;
    if (D_icode == ICALL || D_icode == IJXX)
      d_valA = D_valP;
    else if (d_srcA != RNONE) begin
      if      (d_srcA == e_dstE) d_valA = e_valE;
      else if (d_srcA == M_dstM) d_valA = m_valM;
      else if (d_srcA == M_dstE) d_valA = M_valE;
      else if (d_srcA == W_dstM) d_valA = W_valM;
      else if (d_srcA == W_dstE) d_valA = W_valE;
    end
  end

  always_comb begin
    d_valB = rf_valB;
    if (d_srcB != RNONE) begin
      if      (d_srcB == e_dstE) d_valB = e_valE;
      else if (d_srcB == M_dstM) d_valB = m_valM;
      else if (d_srcB == M_dstE) d_valB = M_valE;
      else if (d_srcB == W_dstM) d_valB = W_valM;
      else if (d_srcB == W_dstE) d_valB = W_valE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      E_stat       <= SAOK;
      E_icode      <= INOP;
      E_ifun       <= 4'h0;
      E_valC       <= 64'h0;
      E_valA       <= 64'h0;
      E_valB       <= 64'h0;
      E_dstE       <= RNONE;
      E_dstM       <= RNONE;
      E_srcA       <= RNONE;
      E_srcB       <= RNONE;
      bubble_count <= 16'h0;
    end else if (E_bubble) begin
      E_stat  <= SAOK;
      E_icode <= INOP;
      E_ifun  <= 4'h0;
      E_valC  <= 64'h0;
      E_valA  <= 64'h0;
      E_valB  <= 64'h0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
      if (bubble_count != 16'hFFFF)
        bubble_count <= bubble_count + 16'd1;
    end else if (!E_stall) begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_e_pipe_reg.sv
`default_nettype none
// ============================================================================
// tb_e_pipe_reg : vector table + scoreboard bench for e_pipe_reg
// Revision      : 1.0  initial release
// ============================================================================
module tb_e_pipe_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP, rf_valA, rf_valB;
  logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic        E_stall = 1'b0, E_bubble = 1'b0;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [15:0] bubble_count;

  e_pipe_reg dut (
    .clk(clk), .rst(rst),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .rf_valA(rf_valA), .rf_valB(rf_valB),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstM(M_dstM), .M_dstE(M_dstE), .m_valM(m_valM), .M_valE(M_valE),
    .W_dstM(W_dstM), .W_dstE(W_dstE), .W_valM(W_valM), .W_valE(W_valE),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  stat, icode, ifun, dstE, dstM, srcA, srcB;
    logic [63:0] valC, valA, valB;
  } e_t;

  typedef struct {
    string       name;
    logic [3:0]  stat, icode, ifun, rA, rB;
    logic [63:0] valC, valP, rfA, rfB;
    logic [3:0]  eE, mM, mE, wM, wE;
    logic [63:0] eVE, mVM, mVE, wVM, wVE;
    logic [3:0]  x_sA, x_sB, x_dE, x_dM;
    logic [63:0] x_vA, x_vB;
  } vec_t;

  typedef struct {
    string       name;
    e_t          e;
    logic [15:0] bc;
  } sb_t;

  localparam e_t BUBBLE = '{stat: 4'h1, icode: 4'h1, ifun: 4'h0, dstE: 4'hF, dstM: 4'hF,
                            srcA: 4'hF, srcB: 4'hF, valC: 64'h0, valA: 64'h0, valB: 64'h0};

  int   nvec  = 0;
  int   nfail = 0;
  vec_t vt[$];
  sb_t  sb[$];

  function automatic vec_t base(string n, logic [3:0] ic, logic [3:0] ra, logic [3:0] rb);
    vec_t v;
    v.name = n; v.stat = 4'h1; v.icode = ic; v.ifun = 4'h0; v.rA = ra; v.rB = rb;
    v.valC = 64'h1111; v.valP = 64'h2222; v.rfA = 64'hAAAA; v.rfB = 64'hBBBB;
    v.eE = 4'hF; v.mM = 4'hF; v.mE = 4'hF; v.wM = 4'hF; v.wE = 4'hF;
    v.eVE = 64'hE0E0; v.mVM = 64'hD0D0; v.mVE = 64'hC0C0; v.wVM = 64'h3030; v.wVE = 64'h4040;
    v.x_sA = 4'hF; v.x_sB = 4'hF; v.x_dE = 4'hF; v.x_dM = 4'hF;
    v.x_vA = 64'hAAAA; v.x_vB = 64'hBBBB;
    return v;
  endfunction

  function automatic e_t exp_of(vec_t v);
    e_t e;
    e.stat = v.stat; e.icode = v.icode; e.ifun = v.ifun;
    e.dstE = v.x_dE; e.dstM = v.x_dM; e.srcA = v.x_sA; e.srcB = v.x_sB;
    e.valC = v.valC; e.valA = v.x_vA; e.valB = v.x_vB;
    return e;
  endfunction

  function automatic e_t actual();
    e_t e;
    e.stat = E_stat; e.icode = E_icode; e.ifun = E_ifun;
    e.dstE = E_dstE; e.dstM = E_dstM; e.srcA = E_srcA; e.srcB = E_srcB;
    e.valC = E_valC; e.valA = E_valA; e.valB = E_valB;
    return e;
  endfunction

  task automatic drive(input vec_t v);
    D_stat = v.stat; D_icode = v.icode; D_ifun = v.ifun; D_rA = v.rA; D_rB = v.rB;
    D_valC = v.valC; D_valP = v.valP; rf_valA = v.rfA; rf_valB = v.rfB;
    e_dstE = v.eE; M_dstM = v.mM; M_dstE = v.mE; W_dstM = v.wM; W_dstE = v.wE;
    e_valE = v.eVE; m_valM = v.mVM; M_valE = v.mVE; W_valM = v.wVM; W_valE = v.wVE;
  endtask

  task automatic check_e(input string n, input e_t exp);
    e_t act;
    act = actual();
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: E regs got %h, expected %h", n, act, exp);
    end
  endtask

  task automatic check_bc(input string n, input logic [15:0] exp);
    nvec++;
    if (bubble_count !== exp) begin
      nfail++;
      $display("FAIL %s: bubble_count got %h, expected %h", n, bubble_count, exp);
    end
  endtask

  task automatic check_src(input vec_t v);
    nvec++;
    if (d_srcA !== v.x_sA || d_srcB !== v.x_sB) begin
      nfail++;
      $display("FAIL %s_src: d_srcA/B got %h/%h, expected %h/%h",
               v.name, d_srcA, d_srcB, v.x_sA, v.x_sB);
    end
  endtask

  task automatic push(input string n, input e_t e, input logic [15:0] bc);
    sb_t s;
    s.name = n; s.e = e; s.bc = bc;
    sb.push_back(s);
  endtask

  task automatic edge_check();
    sb_t s;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      nvec++; nfail++;
      $display("FAIL scoreboard: empty at edge, expected an entry");
    end else begin
      s = sb.pop_front();
      check_e(s.name, s.e);
      check_bc(s.name, s.bc);
    end
  endtask

  initial begin
    vec_t v;

    v = base("opq", 4'h6, 4'h2, 4'h3); v.rfA = 64'd5; v.rfB = 64'd7;
    v.x_sA = 4'h2; v.x_sB = 4'h3; v.x_dE = 4'h3; v.x_vA = 64'd5; v.x_vB = 64'd7; vt.push_back(v);
    v.name = "opq_fwd_e"; v.eE = 4'h2; v.eVE = 64'd99; v.mE = 4'h2; v.mVE = 64'd55;
    v.x_vA = 64'd99; vt.push_back(v);
    v = vt[0]; v.name = "opq_fwd_wm"; v.wM = 4'h3; v.wVM = 64'd11; v.x_vB = 64'd11; vt.push_back(v);
    v = base("call", 4'h8, 4'hF, 4'hF); v.valP = 64'h40; v.rfB = 64'h100;
    v.x_sB = 4'h4; v.x_dE = 4'h4; v.x_vA = 64'h40; v.x_vB = 64'h100; vt.push_back(v);
    v = base("popq", 4'hB, 4'h5, 4'hF); v.rfA = 64'h77;
    v.x_sA = 4'h4; v.x_sB = 4'h4; v.x_dE = 4'h4; v.x_dM = 4'h5; v.x_vA = 64'h77; vt.push_back(v);
    v = base("ret", 4'h9, 4'hF, 4'hF); v.stat = 4'h3; v.ifun = 4'h5;
    v.x_sA = 4'h4; v.x_sB = 4'h4; v.x_dE = 4'h4; vt.push_back(v);
    v = base("jxx", 4'h7, 4'hF, 4'hF); v.ifun = 4'h3; v.valP = 64'h99; v.x_vA = 64'h99; vt.push_back(v);
    v = base("rrmov_mm", 4'h2, 4'h1, 4'h6); v.mM = 4'h1; v.mVM = 64'h123; v.mE = 4'h1;
    v.mVE = 64'h456; v.wE = 4'h1; v.x_sA = 4'h1; v.x_dE = 4'h6; v.x_vA = 64'h123; vt.push_back(v);
    v = base("mrmov_we", 4'h5, 4'h3, 4'h7); v.wE = 4'h7; v.wVE = 64'h789;
    v.x_sB = 4'h7; v.x_dM = 4'h3; v.x_vB = 64'h789; vt.push_back(v);
    v = base("irmov_none", 4'h3, 4'hF, 4'h2); v.valC = 64'hDEAD_BEEF_0000_0001; v.x_dE = 4'h2; vt.push_back(v);
    v = base("unknown_c", 4'hC, 4'h1, 4'h2); v.stat = 4'h4; v.eE = 4'h1; v.mM = 4'h2; vt.push_back(v);
    v = base("pushq_me", 4'hA, 4'h8, 4'hF); v.mE = 4'h4; v.mVE = 64'h5; v.wM = 4'h8;
    v.x_sA = 4'h8; v.x_sB = 4'h4; v.x_dE = 4'h4; v.x_vA = 64'h3030; v.x_vB = 64'h5; vt.push_back(v);
    v = base("rmmov_wm_e", 4'h4, 4'h9, 4'hA); v.wM = 4'h9; v.eE = 4'hA; v.wE = 4'hA;
    v.x_sA = 4'h9; v.x_sB = 4'hA; v.x_vA = 64'h3030; v.x_vB = 64'hE0E0; vt.push_back(v);
    v = base("popq_mm_over_me", 4'hB, 4'h5, 4'hF); v.mM = 4'h4; v.mE = 4'h4;
    v.x_sA = 4'h4; v.x_sB = 4'h4; v.x_dE = 4'h4; v.x_dM = 4'h5;
    v.x_vA = 64'hD0D0; v.x_vB = 64'hD0D0; vt.push_back(v);

    // Asynchronous reset, asserted away from any clock edge
    drive(vt[0]);
    #1 rst = 1'b1;
    #1;
    check_e("reset_async", BUBBLE);
    check_bc("reset_async", 16'h0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    check_e("reset_held", BUBBLE);
    check_bc("reset_held", 16'h0);

    foreach (vt[i]) begin
      drive(vt[i]);
      #1 check_src(vt[i]);
      push(vt[i].name, exp_of(vt[i]), 16'h0);
      edge_check();
    end

    // Stall holds E while decode keeps changing; then bubble overrides stall
    drive(vt[0]); push("stall_load", exp_of(vt[0]), 16'h0); edge_check();
    E_stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive(vt[k + 3]);
      push($sformatf("stall_hold%0d", k), exp_of(vt[0]), 16'h0);
      edge_check();
    end
    E_bubble = 1'b1;
    push("bubble_and_stall", BUBBLE, 16'd1); edge_check();
    E_stall = 1'b0;
    push("bubble_only", BUBBLE, 16'd2); edge_check();
    E_bubble = 1'b0;
    drive(vt[1]); push("after_bubble", exp_of(vt[1]), 16'd2); edge_check();

    // Reset mid-operation discards the in-flight load
    drive(vt[3]);
    #3 rst = 1'b1;
    #1;
    check_e("mid_reset", BUBBLE);
    check_bc("mid_reset", 16'h0);
    push("mid_reset_edge", BUBBLE, 16'h0); edge_check();
    rst = 1'b0;
    push("post_reset_load", exp_of(vt[3]), 16'h0); edge_check();

    // Saturation of bubble_count
    E_bubble = 1'b1;
    for (int i = 1; i <= 65540; i++) begin
      @(posedge clk);
      #1;
      if (i == 1 || i == 65534 || i == 65535 || i == 65540)
        check_bc($sformatf("sat_%0d", i), (i > 65535) ? 16'hFFFF : 16'(i));
    end
    E_bubble = 1'b0;
    E_stall  = 1'b1;
    drive(vt[2]);
    push("sat_hold", BUBBLE, 16'hFFFF); edge_check();
    E_stall = 1'b0;
    push("sat_load", exp_of(vt[2]), 16'hFFFF); edge_check();

    if (sb.size() != 0) begin
      nvec++; nfail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
